// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced multi-key press controller.
// Each active-low key is synchronized, sampled on a shared 10 ms tick and
// classified as SHORT or LONG. Events wait in a one-deep per-key pending slot,
// are granted lowest-index first into a small FIFO and leave over valid/ready.
// Optional feature macro: KEY_REPEAT_EN (REPEAT events while a LONG press is held).
module key_event_ctrl #(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned IDXW        = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [N_KEYS-1:0]   key_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [IDXW+1:0]     evt_data_o,
  output logic                evt_ovf_o
);

  localparam int unsigned TICK_CYC = CLK_FREQ / 100;
  localparam int unsigned TCW      = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TCW-1:0] TICK_MAX = TCW'(TICK_CYC - 1);
  localparam int unsigned HCW      = $clog2(LONG_TICKS + 1);
  localparam logic [HCW-1:0] HOLD_LONG = HCW'(LONG_TICKS);
  localparam logic [HCW-1:0] HOLD_PRE  = HCW'(LONG_TICKS - 1);
  localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam int unsigned DW       = IDXW + 2;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} key_state_e;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
`ifdef KEY_REPEAT_EN
  localparam logic [1:0] EV_REPEAT = 2'b11;
  localparam int unsigned RCW      = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RCW-1:0] RPT_LAST = RCW'(REPEAT_TICKS - 1);
`endif

  // ---------------- input synchronizers and tick ----------------
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [TCW-1:0]    tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_MAX);

  // Two-flop synchronizer per key; idle level (released) out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Free-running tick divider, one-cycle tick at terminal count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // ---------------- per-key press FSMs ----------------
  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [HCW-1:0]    hold_q  [N_KEYS];
  logic [HCW-1:0]    hold_d  [N_KEYS];
  logic [N_KEYS-1:0] raise;
  logic [1:0]        raise_type [N_KEYS];
`ifdef KEY_REPEAT_EN
  logic [RCW-1:0]    rpt_q [N_KEYS];
  logic [RCW-1:0]    rpt_d [N_KEYS];
`endif

  // Key FSM state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state_q[i] <= S_IDLE;
        hold_q[i]  <= '0;
`ifdef KEY_REPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
`ifdef KEY_REPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  // Key FSM next state and event raise, evaluated only on tick.
  always_comb begin
    raise = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      state_d[i]    = state_q[i];
      hold_d[i]     = hold_q[i];
      raise_type[i] = EV_NONE;
`ifdef KEY_REPEAT_EN
      rpt_d[i]      = rpt_q[i];
`endif
      if (tick) begin
        case (state_q[i])
          S_IDLE: begin
            if (!sync2_q[i]) state_d[i] = S_PRESS;
          end
          S_PRESS: begin
            if (!sync2_q[i]) begin
              state_d[i] = S_HELD;
              hold_d[i]  = '0;
            end else begin
              state_d[i] = S_IDLE;
            end
          end
          S_HELD: begin
            if (sync2_q[i]) begin
              state_d[i] = S_REL;
            end else if (hold_q[i] < HOLD_LONG) begin
              hold_d[i] = hold_q[i] + 1'b1;
              if (hold_q[i] == HOLD_PRE) begin
                raise[i]      = 1'b1;
                raise_type[i] = EV_LONG;
`ifdef KEY_REPEAT_EN
                rpt_d[i]      = '0;
`endif
              end
            end
`ifdef KEY_REPEAT_EN
            else if (rpt_q[i] == RPT_LAST) begin
              rpt_d[i]      = '0;
              raise[i]      = 1'b1;
              raise_type[i] = EV_REPEAT;
            end else begin
              rpt_d[i] = rpt_q[i] + 1'b1;
            end
`endif
          end
          S_REL: begin
            if (sync2_q[i]) begin
              state_d[i] = S_IDLE;
              if (hold_q[i] < HOLD_LONG) begin
                raise[i]      = 1'b1;
                raise_type[i] = EV_SHORT;
              end
            end else begin
              state_d[i] = S_HELD;
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // ---------------- pending slots and arbiter ----------------
  logic [N_KEYS-1:0] pend_v_q, pend_v_d;
  logic [1:0]        pend_t_q [N_KEYS];
  logic [1:0]        pend_t_d [N_KEYS];
  logic [N_KEYS-1:0] gnt;
  logic              push;
  logic [DW-1:0]     push_data;
  logic              ovf_d, ovf_q;
  logic              full, empty, pop;

  // Fixed-priority grant: lowest-index valid slot, only when FIFO not full.
  always_comb begin
    gnt       = '0;
    push      = 1'b0;
    push_data = '0;
    if (!full) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (pend_v_q[i] && !push) begin
          gnt[i]    = 1'b1;
          push      = 1'b1;
          push_data = {pend_t_q[i], IDXW'(i)};
        end
      end
    end
  end

  // Slot update: grant clears, raise sets; a raise onto a still-occupied slot overwrites and flags loss.
  always_comb begin
    ovf_d = 1'b0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      pend_v_d[i] = pend_v_q[i] & ~gnt[i];
      pend_t_d[i] = pend_t_q[i];
      if (raise[i]) begin
        if (pend_v_q[i] && !gnt[i]) ovf_d = 1'b1;
        pend_v_d[i] = 1'b1;
        pend_t_d[i] = raise_type[i];
      end
    end
  end

  // Pending slot and overflow pulse registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_v_q <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) pend_t_q[i] <= EV_NONE;
    end else begin
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < N_KEYS; i++) pend_t_q[i] <= pend_t_d[i];
    end
  end

  // ---------------- event FIFO ----------------
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign pop   = !empty && evt_ready_i;

  // FIFO storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers and occupancy; explicit wrap keeps non-power-of-two widths safe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign evt_valid_o = !empty;
  assign evt_data_o  = mem_q[rd_ptr_q];
  assign evt_ovf_o   = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed scenarios followed by random
// key/ready traffic, all checked cycle by cycle against a behavioural model.
module tb_key_event_ctrl;

  localparam int unsigned CLK_FREQ     = 1000;
  localparam int unsigned N_KEYS       = 4;
  localparam int unsigned LONG_TICKS   = 5;
  localparam int unsigned REPEAT_TICKS = 2;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned TICK_CYC     = CLK_FREQ / 100;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [N_KEYS-1:0] key_i;
  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [3:0]        evt_data_o;
  logic              evt_ovf_o;

  key_event_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .N_KEYS      (N_KEYS),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .key_i       (key_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_data_o  (evt_data_o),
    .evt_ovf_o   (evt_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;

  // Behavioural model: a press is two consecutive low tick samples, a release
  // two consecutive high samples; hold counts low samples while pressed.
  int unsigned       m_cnt;
  bit [N_KEYS-1:0]   m_s1, m_s2;
  bit                m_down [N_KEYS];
  int unsigned       m_lo   [N_KEYS];
  int unsigned       m_hi   [N_KEYS];
  int unsigned       m_hold [N_KEYS];
  int unsigned       m_rpt  [N_KEYS];
  bit                m_pv   [N_KEYS];
  logic [1:0]        m_pt   [N_KEYS];
  logic [3:0]        m_q [$];
  bit                m_ovf;

  logic [3:0]        dlog [$];
  int unsigned       dlog_cyc [$];
  logic [3:0]        exp_q [$];
  bit                ovf_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0;
    m_s1  = '1;
    m_s2  = '1;
    m_ovf = 1'b0;
    m_q.delete();
    for (int i = 0; i < N_KEYS; i++) begin
      m_down[i] = 1'b0; m_lo[i] = 0; m_hi[i] = 0; m_hold[i] = 0; m_rpt[i] = 0;
      m_pv[i] = 1'b0; m_pt[i] = 2'b00;
    end
  endtask

  task automatic key_tick(input int k, input bit s, output logic [1:0] rt);
    int unsigned hi_before;
    rt = 2'b00;
    if (!m_down[k]) begin
      if (s) m_lo[k] = 0;
      else begin
        m_lo[k]++;
        if (m_lo[k] == 2) begin
          m_down[k] = 1'b1; m_lo[k] = 0; m_hold[k] = 0; m_hi[k] = 0;
        end
      end
    end else if (!s) begin
      hi_before = m_hi[k];
      m_hi[k]   = 0;
      if (hi_before == 0) begin
        if (m_hold[k] < LONG_TICKS) begin
          m_hold[k]++;
          if (m_hold[k] == LONG_TICKS) begin
            m_rpt[k] = 0;
            rt = 2'b10;
          end
        end
`ifdef KEY_REPEAT_EN
        else begin
          m_rpt[k]++;
          if (m_rpt[k] == REPEAT_TICKS) begin
            m_rpt[k] = 0;
            rt = 2'b11;
          end
        end
`endif
      end
    end else begin
      m_hi[k]++;
      if (m_hi[k] == 2) begin
        m_down[k] = 1'b0; m_lo[k] = 0; m_hi[k] = 0;
        if (m_hold[k] < LONG_TICKS) rt = 2'b01;
      end
    end
  endtask

  // One clock: capture pre-edge handshake, advance model, compare #1 after edge.
  task automatic step();
    logic       pre_v, pre_r;
    logic [3:0] pre_d, pushval;
    bit         tk, full;
    int         g;
    logic [1:0] rt;
    pre_v = evt_valid_o;
    pre_d = evt_data_o;
    pre_r = evt_ready_i;
    @(posedge clk_i);
    cyc++;
    if (!rstn_i) begin
      m_reset();
    end else begin
      if (pre_v && pre_r) begin
        dlog.push_back(pre_d);
        dlog_cyc.push_back(cyc);
      end
      full = (m_q.size() == FIFO_DEPTH);
      g = -1;
      if (!full) begin
        for (int i = 0; i < N_KEYS; i++) if (m_pv[i] && g < 0) g = i;
      end
      pushval = 4'h0;
      if (g >= 0) begin
        pushval = {m_pt[g], 2'(g)};
        m_pv[g] = 1'b0;
      end
      tk    = (m_cnt == TICK_CYC - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      m_ovf = 1'b0;
      if (tk) begin
        for (int k = 0; k < N_KEYS; k++) begin
          key_tick(k, m_s2[k], rt);
          if (rt != 2'b00) begin
            if (m_pv[k]) m_ovf = 1'b1;
            m_pv[k] = 1'b1;
            m_pt[k] = rt;
          end
        end
      end
      if (m_q.size() != 0 && pre_r) void'(m_q.pop_front());
      if (g >= 0) m_q.push_back(pushval);
      m_s2 = m_s1;
      m_s1 = key_i;
    end
    #1;
    check("valid", 32'(evt_valid_o), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("data", 32'(evt_data_o), 32'(m_q[0]));
    check("ovf", 32'(evt_ovf_o), 32'(m_ovf));
    if (evt_ovf_o === 1'b1) ovf_seen = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    dlog.delete();
    dlog_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 32'(dlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < dlog.size()) ? 32'(dlog[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
  endtask

  task automatic short_press_k0();
    key_i[0] = 1'b0; run(30);
    key_i[0] = 1'b1; run(30);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    key_i       = '1;
    evt_ready_i = 1'b1;
    rstn_i      = 1'b1;
    ovf_seen    = 1'b0;
    m_reset();
    #1 rstn_i = 1'b0;
    #1;
    check("rst_valid", 32'(evt_valid_o), 32'h0);
    check("rst_data",  32'(evt_data_o),  32'h0);
    check("rst_ovf",   32'(evt_ovf_o),   32'h0);
    run(2);
    rstn_i = 1'b1;
    run(5);

    // Short press on key 1.
    clear_log();
    key_i[1] = 1'b0; run(30);
    key_i[1] = 1'b1; run(60);
    exp_q.push_back(4'h5);
    check_log("short_k1");

    // Single-tick glitch on key 2: nothing.
    clear_log();
    ovf_seen = 1'b0;
    key_i[2] = 1'b0; run(10);
    key_i[2] = 1'b1; run(40);
    check_log("glitch_k2");
    check("glitch_ovf", 32'(ovf_seen), 32'h0);

    // Long hold on key 0.
    clear_log();
    key_i[0] = 1'b0; run(100);
    key_i[0] = 1'b1; run(50);
    exp_q.push_back(4'h8);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(4'hC);
`endif
    check_log("long_k0");

    // Keys 3 and 1 released together: drain in index order back-to-back.
    clear_log();
    key_i[3] = 1'b0; key_i[1] = 1'b0; run(30);
    key_i[3] = 1'b1; key_i[1] = 1'b1; run(60);
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h7);
    check_log("simul_k31");
    check("simul_gap", (dlog_cyc.size() == 2) ? 32'(dlog_cyc[1] - dlog_cyc[0]) : 32'hffff_ffff, 32'd1);

    // Backpressure: 4 queued, 5th pending, 6th overwrites.
    clear_log();
    evt_ready_i = 1'b0;
    ovf_seen    = 1'b0;
    for (int p = 0; p < 6; p++) short_press_k0();
    check("bp_ovf_seen", 32'(ovf_seen), 32'h1);
    check("bp_valid", 32'(evt_valid_o), 32'h1);
    evt_ready_i = 1'b1;
    run(20);
    for (int p = 0; p < 5; p++) exp_q.push_back(4'h4);
    check_log("bp_drain");

    // Reset mid-HELD with two queued entries.
    clear_log();
    evt_ready_i = 1'b0;
    short_press_k0();
    short_press_k0();
    key_i[2] = 1'b0; run(40);
    #2 rstn_i = 1'b0;
    #1;
    m_reset();
    check("mrst_valid", 32'(evt_valid_o), 32'h0);
    check("mrst_data",  32'(evt_data_o),  32'h0);
    check("mrst_ovf",   32'(evt_ovf_o),   32'h0);
    key_i[2] = 1'b1;
    run(3);
    rstn_i = 1'b1;
    evt_ready_i = 1'b1;
    clear_log();
    run(60);
    check_log("mrst_after");

    // Random traffic in three phases: fast keys/ready mostly high, fast keys/ready mostly low, slow keys.
    for (int c = 0; c < 9000; c++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (c < 6000) begin
          if ($urandom_range(0, 29) == 0) key_i[k] = ~key_i[k];
        end else begin
          if ($urandom_range(0, 79) == 0) key_i[k] = ~key_i[k];
        end
      end
      if (c < 3000)      evt_ready_i = ($urandom_range(0, 3) != 0);
      else if (c < 6000) evt_ready_i = ($urandom_range(0, 3) == 0);
      else               evt_ready_i = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
